// File: rtl/uop_loop_seq.sv
// rtl/uop_loop_seq.sv - micro-op loop sequencer: walks outer/inner/upc nest and streams offset beats
// Offsets accumulate per loop level and are summed on the output; all sums wrap at port width.
module uop_loop_seq #(
  parameter int UPC_W  = 14,
  parameter int ITER_W = 14,
  parameter int ACC_W  = 11,
  parameter int INP_W  = 11,
  parameter int WGT_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [UPC_W-1:0]  cfg_uop_bgn,
  input  logic [UPC_W-1:0]  cfg_uop_end,
  input  logic [ITER_W-1:0] cfg_iter_out,
  input  logic [ITER_W-1:0] cfg_iter_in,
  input  logic [ACC_W-1:0]  cfg_dst_fo,
  input  logic [ACC_W-1:0]  cfg_dst_fi,
  input  logic [INP_W-1:0]  cfg_src_fo,
  input  logic [INP_W-1:0]  cfg_src_fi,
  input  logic [WGT_W-1:0]  cfg_wgt_fo,
  input  logic [WGT_W-1:0]  cfg_wgt_fi,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [UPC_W-1:0]  out_upc,
  output logic [ACC_W-1:0]  out_dst_off,
  output logic [INP_W-1:0]  out_src_off,
  output logic [WGT_W-1:0]  out_wgt_off
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;

  logic [UPC_W-1:0]  bgn_q, end_q;
  logic [ITER_W-1:0] iter_out_n_q, iter_in_n_q;
  logic [ACC_W-1:0]  dst_fo_q, dst_fi_q;
  logic [INP_W-1:0]  src_fo_q, src_fi_q;
  logic [WGT_W-1:0]  wgt_fo_q, wgt_fi_q;

  logic [UPC_W-1:0]  upc;
  logic [ITER_W-1:0] iter_out, iter_in;
  logic [ACC_W-1:0]  dst_out, dst_in;
  logic [INP_W-1:0]  src_out, src_in;
  logic [WGT_W-1:0]  wgt_out, wgt_in;

  logic              run;
  logic              empty_job;
  logic [UPC_W-1:0]  upc_nxt;
  logic [ITER_W-1:0] iter_in_nxt, iter_out_nxt;
  logic              upc_wrap, in_wrap, out_wrap;

  assign run       = (state == S_RUN);
  assign empty_job = (cfg_iter_out == '0) || (cfg_iter_in == '0) || (cfg_uop_end <= cfg_uop_bgn);

  assign upc_nxt      = upc + 1'b1;
  assign iter_in_nxt  = iter_in + 1'b1;
  assign iter_out_nxt = iter_out + 1'b1;
  assign upc_wrap     = (upc_nxt == end_q);
  assign in_wrap      = (iter_in_nxt == iter_in_n_q);
  assign out_wrap     = (iter_out_nxt == iter_out_n_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      bgn_q        <= '0;
      end_q        <= '0;
      iter_out_n_q <= '0;
      iter_in_n_q  <= '0;
      dst_fo_q     <= '0;
      dst_fi_q     <= '0;
      src_fo_q     <= '0;
      src_fi_q     <= '0;
      wgt_fo_q     <= '0;
      wgt_fi_q     <= '0;
      upc          <= '0;
      iter_out     <= '0;
      iter_in      <= '0;
      dst_out      <= '0;
      dst_in       <= '0;
      src_out      <= '0;
      src_in       <= '0;
      wgt_out      <= '0;
      wgt_in       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            bgn_q        <= cfg_uop_bgn;
            end_q        <= cfg_uop_end;
            iter_out_n_q <= cfg_iter_out;
            iter_in_n_q  <= cfg_iter_in;
            dst_fo_q     <= cfg_dst_fo;
            dst_fi_q     <= cfg_dst_fi;
            src_fo_q     <= cfg_src_fo;
            src_fi_q     <= cfg_src_fi;
            wgt_fo_q     <= cfg_wgt_fo;
            wgt_fi_q     <= cfg_wgt_fi;
            upc          <= cfg_uop_bgn;
            iter_out     <= '0;
            iter_in      <= '0;
            dst_out      <= '0;
            dst_in       <= '0;
            src_out      <= '0;
            src_in       <= '0;
            wgt_out      <= '0;
            wgt_in       <= '0;
            state        <= empty_job ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (out_ready) begin
            if (!upc_wrap) begin
              upc <= upc_nxt;
            end else begin
              upc <= bgn_q;
              if (!in_wrap) begin
                iter_in <= iter_in_nxt;
                dst_in  <= dst_in + dst_fi_q;
                src_in  <= src_in + src_fi_q;
                wgt_in  <= wgt_in + wgt_fi_q;
              end else begin
                // inner loop rolls over: restart inner offsets, step the outer level
                iter_in <= '0;
                dst_in  <= '0;
                src_in  <= '0;
                wgt_in  <= '0;
                if (!out_wrap) begin
                  iter_out <= iter_out_nxt;
                  dst_out  <= dst_out + dst_fo_q;
                  src_out  <= src_out + src_fo_q;
                  wgt_out  <= wgt_out + wgt_fo_q;
                end else begin
                  state <= S_DONE;
                end
              end
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Payload is gated by state so reset clears it combinationally, without waiting for a clock.
  assign busy        = run;
  assign done        = (state == S_DONE);
  assign out_valid   = run;
  assign out_upc     = run ? upc : '0;
  assign out_dst_off = run ? ACC_W'(dst_out + dst_in) : '0;
  assign out_src_off = run ? INP_W'(src_out + src_in) : '0;
  assign out_wgt_off = run ? WGT_W'(wgt_out + wgt_in) : '0;

endmodule
